cnna_sdiv_32s_15ns_26_seq: RTL and testbench



---
 rtl/cnna_sdiv_32s_15ns_26_seq_pkg.sv | 10 +
 rtl/cnna_sdiv_32s_15ns_26_seq_core.sv | 47 ++++
 rtl/cnna_sdiv_32s_15ns_26_seq.sv | 73 +++++++
 tb/tb_cnna_sdiv_32s_15ns_26_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cnna_sdiv_32s_15ns_26_seq_pkg.sv
// cnna_sdiv_32s_15ns_26_seq_pkg: shared widths, FSM encoding and saturation limits for the divider
package cnna_sdiv_32s_15ns_26_seq_pkg;
    localparam int DIVIDEND_WIDTH = 32;
    localparam int DIVISOR_WIDTH  = 15;
    localparam int QUOT_WIDTH     = 26;
    localparam int REM_WIDTH      = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
    localparam logic [QUOT_WIDTH-1:0] QUOT_MAX = 26'h1FFFFFF;
    localparam logic [QUOT_WIDTH-1:0] QUOT_MIN = 26'h2000000;
endpackage

// File: rtl/cnna_sdiv_32s_15ns_26_seq_core.sv
// cnna_udiv_32u_15u_core: unsigned restoring divider, one quotient bit per cycle, 32 cycles per load
module cnna_udiv_32u_15u_core
    import cnna_sdiv_32s_15ns_26_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      last,
    output logic [DIVIDEND_WIDTH-1:0] quo,
    output logic [REM_WIDTH-1:0]      rmd
);
    logic [REM_WIDTH-1:0]      pr;
    logic [DIVIDEND_WIDTH-1:0] q;
    logic [DIVISOR_WIDTH-1:0]  d;
    logic [4:0]                cnt;
    logic [REM_WIDTH-1:0]      shifted;
    logic [REM_WIDTH:0]        diff;
    // q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign shifted = {pr[REM_WIDTH-2:0], q[DIVIDEND_WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, d};
    assign last    = busy && cnt == 5'd31;
    assign quo     = q;
    assign rmd     = pr;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            pr   <= '0;
            q    <= '0;
            d    <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= '0;
            pr   <= '0;
            q    <= dividend;
            d    <= divisor;
        end else if (busy) begin
            pr   <= diff[REM_WIDTH] ? shifted : diff[REM_WIDTH-1:0];
            q    <= {q[DIVIDEND_WIDTH-2:0], ~diff[REM_WIDTH]};
            cnt  <= cnt + 5'd1;
            busy <= !last;
        end
    end
endmodule

// File: rtl/cnna_sdiv_32s_15ns_26_seq.sv
// cnna_sdiv_32s_15ns_26_seq: signed 32b / unsigned 15b divider with saturated 26b quotient and ap_* handshake
module cnna_sdiv_32s_15ns_26_seq
    import cnna_sdiv_32s_15ns_26_seq_pkg::*;
(
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [DIVIDEND_WIDTH-1:0]     din0,
    input  logic [DIVISOR_WIDTH-1:0]      din1,
    output logic signed [QUOT_WIDTH-1:0]  quot,
    output logic signed [REM_WIDTH-1:0]   rem,
    output logic                          ovf,
    output logic                          dbz
);
    state_t                    state;
    logic                      neg, zdiv, busy, last;
    logic [DIVIDEND_WIDTH-1:0] mag, qm;
    logic [REM_WIDTH-1:0]      rm, fr;
    logic [QUOT_WIDTH-1:0]     fq;
    logic                      fo;
    assign ap_idle  = state == IDLE;
    assign ap_done  = state == DONE;
    assign ap_ready = ap_idle && ap_start && !ap_rst;
    assign mag      = din0[DIVIDEND_WIDTH-1] ? ~din0 + 32'd1 : din0;
    cnna_udiv_32u_15u_core u_core (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .load     (ap_ready),
        .dividend (mag),
        .divisor  (din1),
        .busy     (busy),
        .last     (last),
        .quo      (qm),
        .rmd      (rm)
    );
    // a negative result may reach -2^25, one step further than the positive limit
    always_comb begin
        fo = zdiv ? 1'b0 : neg ? (qm > 32'h2000000) : (qm > 32'h1FFFFFF);
        fq = (zdiv || fo) ? (neg ? QUOT_MIN : QUOT_MAX) : neg ? -qm[QUOT_WIDTH-1:0] : qm[QUOT_WIDTH-1:0];
        fr = zdiv ? '0 : neg ? -rm : rm;
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            neg   <= 1'b0;
            zdiv  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ap_start) begin
                    neg   <= din0[DIVIDEND_WIDTH-1];
                    zdiv  <= din1 == '0;
                    state <= CALC;
                end
                CALC: if (last) state <= FIX;
                FIX: begin
                    quot  <= fq;
                    rem   <= fr;
                    ovf   <= fo;
                    dbz   <= zdiv;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnna_sdiv_32s_15ns_26_seq.sv
// tb_cnna_sdiv_32s_15ns_26_seq: directed and random divisions checked against an arithmetic reference
module tb_cnna_sdiv_32s_15ns_26_seq;
    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               ap_start = 1'b0;
    logic               ap_ready, ap_idle, ap_done, ovf, dbz;
    logic [31:0]        din0 = '0;
    logic [14:0]        din1 = '0;
    logic signed [25:0] quot;
    logic signed [15:0] rem;
    int                 nvec = 0;
    int                 nerr = 0;

    cnna_sdiv_32s_15ns_26_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .quot     (quot),
        .rem      (rem),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // truncating division with saturation to the 26-bit signed range
    task automatic model(input longint a, input longint d, output longint eq, output longint er,
                         output longint eo, output longint ez);
        longint q;
        eo = 0;
        ez = (d == 0);
        if (d == 0) begin
            eq = (a >= 0) ? 33554431 : -33554432;
            er = 0;
        end else begin
            q  = a / d;
            er = a % d;
            eo = (q > 33554431 || q < -33554432);
            eq = (q > 33554431) ? 33554431 : (q < -33554432) ? -33554432 : q;
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [14:0] d, input int inj, input int rsa);
        int n, bad, dones;
        longint eq, er, eo, ez;
        model(longint'($signed(a)), longint'(d), eq, er, eo, ez);
        @(negedge ap_clk);
        din0 = a; din1 = d; ap_start = 1'b1;
        #1 chk("ready", ap_ready, 1);
        @(negedge ap_clk);
        ap_start = 1'b0; din0 = $urandom; din1 = 15'($urandom);
        n = 1; bad = 0;
        while (!ap_done && n < 60) begin
            if (ap_idle) bad++;
            if (n == inj) begin
                ap_start = 1'b1; din0 = 32'd12345; din1 = 15'd3;
                #1 chk("ignored_ready", ap_ready, 0);
            end
            if (n == inj + 1) ap_start = 1'b0;
            if (n == rsa) begin
                ap_rst = 1'b1;
                @(negedge ap_clk);
                ap_rst = 1'b0;
                chk("abort_idle", ap_idle, 1);
                chk("abort_quot", quot, 0);
                chk("abort_rem", rem, 0);
                chk("abort_flags", {ovf, dbz, ap_done}, 0);
                dones = 0;
                for (int k = 0; k < 25; k++) begin
                    @(negedge ap_clk);
                    if (ap_done) dones++;
                end
                chk("abort_no_done", dones, 0);
                return;
            end
            @(negedge ap_clk);
            n++;
        end
        chk("latency", n, 34);
        chk("busy_not_idle", bad, 0);
        chk("quot", longint'(quot), eq);
        chk("rem", longint'(rem), er);
        chk("ovf", ovf, eo);
        chk("dbz", dbz, ez);
        @(negedge ap_clk);
        chk("done_pulse", ap_done, 0);
        chk("idle_back", ap_idle, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [14:0] d;
        int dones;
        repeat (3) @(negedge ap_clk);
        chk("rst_idle", ap_idle, 1);
        chk("rst_outs", {ap_ready, ap_done, ovf, dbz}, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        ap_rst = 1'b0;
        run(32'd100, 15'd7, -1, -1);
        run(-32'sd100, 15'd7, -1, -1);
        run(-32'sd7, 15'd7, -1, -1);
        run(32'h7FFFFFFF, 15'd1, -1, -1);
        run(32'h80000000, 15'd1, -1, -1);
        run(32'h80000000, 15'd64, -1, -1);
        run(32'd5, 15'd0, -1, -1);
        run(-32'sd5, 15'd0, -1, -1);
        run(32'd0, 15'd0, -1, -1);
        run(32'd77777, 15'd32767, -1, -1);
        run(32'd500, 15'd9, 10, -1);
        run(32'd400, 15'd9, -1, 20);
        run(32'd1000, 15'd3, -1, -1);
        // reset and start together: the start is dropped
        @(negedge ap_clk);
        ap_rst = 1'b1; ap_start = 1'b1; din0 = 32'd9; din1 = 15'd2;
        #1 chk("rst_start_ready", ap_ready, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0; ap_start = 1'b0;
        chk("rst_start_idle", ap_idle, 1);
        // start held high: back-to-back operations, one per 35 cycles
        ap_start = 1'b1; din0 = 32'd50; din1 = 15'd5;
        dones = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge ap_clk);
            if (ap_done) dones++;
        end
        ap_start = 1'b0;
        chk("held_start_dones", dones, 2);
        chk("held_start_quot", quot, 10);
        repeat (40) @(negedge ap_clk);
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            a = $signed(a) >>> $urandom_range(0, 31);
            d = ($urandom_range(0, 5) == 0) ? 15'($urandom_range(0, 3)) : 15'($urandom_range(1, 32767));
            run(a, d, -1, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
